seq_restoring_divider: RTL

- Sequential unsigned restoring divider; inverse datapath to the multiplier/adder arithmetic blocks.
- Produces one quotient bit per clock using a shift/subtract loop, with a start/done handshake.
- Sits beside the Vedic multiplier as the arithmetic unit's divide path.
- Internal subtract is a (WIDTH+1)-bit trial subtraction, so the sign bit doubles as the borrow.

---
 rtl/seq_restoring_divider_if.sv | 24 ++
 rtl/seq_restoring_divider.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_if.sv
// Handshake/operand bundle for seq_restoring_divider.
// master: the requester that drives start and the operands; slave: the divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/done handshake.
// The (WIDTH+1)-bit trial subtraction uses its top bit as the borrow.
// Optional macro SIGNED_DIV_EN: two's-complement operands (magnitudes divided,
// results sign-corrected on the way out, quotient truncates toward zero).
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] qw_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remo_q;
  logic             dbz_q;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] qw_d;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] remo_d;

`ifdef SIGNED_DIV_EN
  logic qneg_q;
  logic rneg_q;
`endif

  // One shift/trial-subtract step plus operand magnitudes and final result shaping
  always_comb begin
    shifted = {rem_q, qw_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr_q};
    qw_d    = {qw_q[WIDTH-2:0], ~trial[WIDTH]};
    rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
`ifdef SIGNED_DIV_EN
    a_mag   = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag   = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    quot_d  = qneg_q ? -qw_q  : qw_q;
    remo_d  = rneg_q ? -rem_q : rem_q;
`else
    a_mag   = bus.dividend;
    b_mag   = bus.divisor;
    quot_d  = qw_q;
    remo_d  = rem_q;
`endif
    // On divide-by-zero qw_q carries the raw dividend straight through
    if (zero_q) begin
      quot_d = '1;
      remo_d = qw_q;
    end
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      qw_q    <= '0;
      dvsr_q  <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            count_q <= '0;
            rem_q   <= '0;
            dvsr_q  <= b_mag;
`ifdef SIGNED_DIV_EN
            qneg_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg_q  <= bus.dividend[WIDTH-1];
`endif
            if (bus.divisor == '0) begin
              qw_q    <= bus.dividend;
              zero_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              qw_q    <= a_mag;
              zero_q  <= 1'b0;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          qw_q    <= qw_d;
          count_q <= count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) state_q <= FINISH;
        end
        FINISH: begin
          quot_q  <= quot_d;
          remo_q  <= remo_d;
          dbz_q   <= zero_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = remo_q;
  assign bus.div_by_zero = dbz_q;
endmodule
